// File: rtl/otg_hpi_responder.sv
// FPGA-side stand-in for the EZ-OTG HPI port: serves DATA/MAILBOX/ADDRESS/STATUS to the
// host over the otg_hpi_* PIO strobes and runs a two-way mailbox with local fabric logic.
module otg_hpi_responder #(
  parameter int MEM_AW = 8
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [1:0]  hpi_addr,
  input  logic [15:0] hpi_data_in,
  output logic [15:0] hpi_data_out,
  input  logic        hpi_r_n,
  input  logic        hpi_w_n,
  input  logic        hpi_cs_n,
  input  logic        hpi_rst_n,
  output logic        hpi_int,
  output logic [15:0] mbx_in_data,
  output logic        mbx_in_valid,
  input  logic        mbx_in_ack,
  input  logic [15:0] mbx_out_data,
  input  logic        mbx_out_wr,
  output logic        mbx_out_busy
);

  typedef enum logic [1:0] {SEL_DATA, SEL_MBX, SEL_ADDR, SEL_STAT} sel_e;

  logic [15:0] mem [2**MEM_AW];
  logic [15:0] mem_rd_q;

  logic        r_n_q, r_n_d;
  logic        w_n_q, w_n_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_out_q, data_out_d;
  logic [15:0] mbx_in_data_q, mbx_in_data_d;
  logic        mbx_in_valid_q, mbx_in_valid_d;
  logic [15:0] mbx_out_word_q, mbx_out_word_d;
  logic        mbx_out_busy_q, mbx_out_busy_d;
  logic        ovr_q, ovr_d;
  logic        err_q, err_d;
  logic        rd_pend_q, rd_pend_d;
  sel_e        rd_sel_q, rd_sel_d;

  logic              rd_start, wr_start, illegal, rd_go, wr_go, mem_we;
  logic [MEM_AW-1:0] mem_idx;
  logic [15:0]       status_w;
  sel_e              sel_in;

  // A start that collides with the other strobe being low is rejected and flagged.
  assign rd_start = r_n_q & ~hpi_r_n & ~hpi_cs_n;
  assign wr_start = w_n_q & ~hpi_w_n & ~hpi_cs_n;
  assign illegal  = (rd_start & ~hpi_w_n) | (wr_start & ~hpi_r_n);
  assign rd_go    = rd_start & ~illegal & hpi_rst_n;
  assign wr_go    = wr_start & ~illegal & hpi_rst_n;
  assign sel_in   = sel_e'(hpi_addr);
  assign mem_idx  = addr_q[MEM_AW:1];
  assign mem_we   = wr_go & (sel_in == SEL_DATA);
  assign status_w = {err_q, 5'd0, ovr_q, mbx_in_valid_q, 7'd0, mbx_out_busy_q};

  always_comb begin
    r_n_d          = hpi_r_n;
    w_n_d          = hpi_w_n;
    addr_d         = addr_q;
    data_out_d     = data_out_q;
    mbx_in_data_d  = mbx_in_data_q;
    mbx_in_valid_d = mbx_in_valid_q;
    mbx_out_word_d = mbx_out_word_q;
    mbx_out_busy_d = mbx_out_busy_q;
    ovr_d          = ovr_q;
    err_d          = err_q;
    rd_pend_d      = rd_go;
    rd_sel_d       = sel_in;

    if (rd_pend_q) begin
      unique case (rd_sel_q)
        SEL_DATA: begin
          data_out_d = mem_rd_q;
          addr_d     = addr_q + 16'd2;
        end
        SEL_MBX: begin
          data_out_d     = mbx_out_word_q;
          mbx_out_busy_d = 1'b0;
        end
        SEL_ADDR: data_out_d = addr_q;
        SEL_STAT: data_out_d = status_w;
      endcase
    end

    // Testing the post against busy_d lets a same-cycle host read-clear admit the new word.
    if (mbx_out_wr && !mbx_out_busy_d) begin
      mbx_out_word_d = mbx_out_data;
      mbx_out_busy_d = 1'b1;
    end

    if (mbx_in_ack) mbx_in_valid_d = 1'b0;
    if (illegal) err_d = 1'b1;

    if (wr_go) begin
      unique case (sel_in)
        SEL_DATA: addr_d = addr_d + 16'd2;
        SEL_MBX: begin
          if (mbx_in_valid_q) ovr_d = 1'b1;
          mbx_in_data_d  = hpi_data_in;
          mbx_in_valid_d = 1'b1;
        end
        SEL_ADDR: addr_d = hpi_data_in;
        SEL_STAT: ;
      endcase
    end

    if (!hpi_rst_n) begin
      addr_d         = 16'd0;
      data_out_d     = 16'd0;
      mbx_in_data_d  = 16'd0;
      mbx_in_valid_d = 1'b0;
      mbx_out_word_d = 16'd0;
      mbx_out_busy_d = 1'b0;
      ovr_d          = 1'b0;
      err_d          = 1'b0;
      rd_pend_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_n_q          <= 1'b1;
      w_n_q          <= 1'b1;
      addr_q         <= 16'd0;
      data_out_q     <= 16'd0;
      mbx_in_data_q  <= 16'd0;
      mbx_in_valid_q <= 1'b0;
      mbx_out_word_q <= 16'd0;
      mbx_out_busy_q <= 1'b0;
      ovr_q          <= 1'b0;
      err_q          <= 1'b0;
      rd_pend_q      <= 1'b0;
      rd_sel_q       <= SEL_DATA;
    end else begin
      r_n_q          <= r_n_d;
      w_n_q          <= w_n_d;
      addr_q         <= addr_d;
      data_out_q     <= data_out_d;
      mbx_in_data_q  <= mbx_in_data_d;
      mbx_in_valid_q <= mbx_in_valid_d;
      mbx_out_word_q <= mbx_out_word_d;
      mbx_out_busy_q <= mbx_out_busy_d;
      ovr_q          <= ovr_d;
      err_q          <= err_d;
      rd_pend_q      <= rd_pend_d;
      rd_sel_q       <= rd_sel_d;
    end
  end

  // Memory has no reset so it maps onto block RAM and survives soft resets.
  always_ff @(posedge clk_clk) begin
    if (mem_we) mem[mem_idx] <= hpi_data_in;
    if (rd_go)  mem_rd_q <= mem[mem_idx];
  end

  assign hpi_data_out = data_out_q;
  assign hpi_int      = mbx_out_busy_q;
  assign mbx_out_busy = mbx_out_busy_q;
  assign mbx_in_data  = mbx_in_data_q;
  assign mbx_in_valid = mbx_in_valid_q;

endmodule

// File: tb/tb_otg_hpi_responder.sv
// Transaction-level reference model of the HPI responder, compared against the DUT on every
// cycle, with directed scenarios pinned by literal values and a randomized traffic phase.
module tb_otg_hpi_responder;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [1:0]  hpi_addr = 2'd0;
  logic [15:0] hpi_data_in = 16'd0;
  logic [15:0] hpi_data_out;
  logic        hpi_r_n = 1'b1;
  logic        hpi_w_n = 1'b1;
  logic        hpi_cs_n = 1'b1;
  logic        hpi_rst_n = 1'b1;
  logic        hpi_int;
  logic [15:0] mbx_in_data;
  logic        mbx_in_valid;
  logic        mbx_in_ack = 1'b0;
  logic [15:0] mbx_out_data = 16'd0;
  logic        mbx_out_wr = 1'b0;
  logic        mbx_out_busy;

  otg_hpi_responder #(.MEM_AW(8)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .hpi_addr(hpi_addr), .hpi_data_in(hpi_data_in), .hpi_data_out(hpi_data_out),
    .hpi_r_n(hpi_r_n), .hpi_w_n(hpi_w_n), .hpi_cs_n(hpi_cs_n), .hpi_rst_n(hpi_rst_n),
    .hpi_int(hpi_int), .mbx_in_data(mbx_in_data), .mbx_in_valid(mbx_in_valid),
    .mbx_in_ack(mbx_in_ack), .mbx_out_data(mbx_out_data), .mbx_out_wr(mbx_out_wr),
    .mbx_out_busy(mbx_out_busy)
  );

  always #5 clk_clk = ~clk_clk;

  int n_pass = 0;
  int n_total = 0;
  bit done = 1'b0;

  // Model state: what the host and local logic should observe.
  logic [15:0] m_mem [256];
  logic [15:0] m_addr = 16'd0, m_dout = 16'd0, m_in_data = 16'd0, m_out_word = 16'd0;
  logic        m_in_valid = 1'b0, m_busy = 1'b0, m_ovr = 1'b0, m_err = 1'b0;
  typedef struct { logic [1:0] sel; logic [15:0] memval; } rd_t;
  rd_t rd_q[$];

  // Events the stimulus announces for the coming clock edge.
  bit          ev_wr, ev_rd, ev_ill, ev_post, ev_ack, ev_srst;
  logic [1:0]  ev_sel;
  logic [15:0] ev_data, ev_post_data;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [15:0] m_status();
    return {m_err, 5'd0, m_ovr, m_in_valid, 7'd0, m_busy};
  endfunction

  task automatic model_edge();
    logic was_valid;
    rd_t r;
    was_valid = m_in_valid;
    if (ev_srst) begin
      m_addr = 0; m_dout = 0; m_in_data = 0; m_in_valid = 0;
      m_out_word = 0; m_busy = 0; m_ovr = 0; m_err = 0;
      rd_q.delete();
      return;
    end
    if (rd_q.size() > 0) begin
      r = rd_q.pop_front();
      case (r.sel)
        2'd0: begin m_dout = r.memval; m_addr = m_addr + 16'd2; end
        2'd1: begin m_dout = m_out_word; m_busy = 1'b0; end
        2'd2: m_dout = m_addr;
        default: m_dout = m_status();
      endcase
    end
    if (ev_post && !m_busy) begin m_out_word = ev_post_data; m_busy = 1'b1; end
    if (ev_ack) m_in_valid = 1'b0;
    if (ev_ill) m_err = 1'b1;
    else if (ev_wr) begin
      case (ev_sel)
        2'd0: begin m_mem[m_addr[8:1]] = ev_data; m_addr = m_addr + 16'd2; end
        2'd1: begin if (was_valid) m_ovr = 1'b1; m_in_data = ev_data; m_in_valid = 1'b1; end
        2'd2: m_addr = ev_data;
        default: ;
      endcase
    end else if (ev_rd) begin
      r.sel = ev_sel;
      r.memval = m_mem[m_addr[8:1]];
      rd_q.push_back(r);
    end
  endtask

  task automatic edge_step();
    @(posedge clk_clk);
    model_edge();
    {ev_wr, ev_rd, ev_ill, ev_post, ev_ack, ev_srst} = '0;
    #1;
  endtask

  always @(negedge clk_clk) begin
    if (!done) begin
      chk("hpi_data_out", hpi_data_out, m_dout);
      chk("hpi_int", {15'd0, hpi_int}, {15'd0, m_busy});
      chk("mbx_out_busy", {15'd0, mbx_out_busy}, {15'd0, m_busy});
      chk("mbx_in_valid", {15'd0, mbx_in_valid}, {15'd0, m_in_valid});
      chk("mbx_in_data", mbx_in_data, m_in_data);
    end
  end

  task automatic host_write(input logic [1:0] sel, input logic [15:0] d, input bit ack);
    hpi_addr = sel; hpi_data_in = d; hpi_cs_n = 0; hpi_w_n = 0;
    ev_wr = 1; ev_sel = sel; ev_data = d;
    if (ack) begin mbx_in_ack = 1; ev_ack = 1; end
    edge_step();
    hpi_cs_n = 1; hpi_w_n = 1; mbx_in_ack = 0;
    edge_step();
  endtask

  task automatic host_read(input logic [1:0] sel, input bit post, input logic [15:0] pd,
                           output logic [15:0] val);
    hpi_addr = sel; hpi_cs_n = 0; hpi_r_n = 0;
    ev_rd = 1; ev_sel = sel;
    edge_step();
    hpi_cs_n = 1; hpi_r_n = 1;
    if (post) begin mbx_out_wr = 1; mbx_out_data = pd; ev_post = 1; ev_post_data = pd; end
    edge_step();
    mbx_out_wr = 0;
    @(negedge clk_clk);
    val = hpi_data_out;
  endtask

  task automatic local_post(input logic [15:0] pd);
    mbx_out_wr = 1; mbx_out_data = pd; ev_post = 1; ev_post_data = pd;
    edge_step();
    mbx_out_wr = 0;
  endtask

  task automatic local_ack();
    mbx_in_ack = 1; ev_ack = 1;
    edge_step();
    mbx_in_ack = 0;
  endtask

  task automatic soft_reset();
    hpi_rst_n = 0; ev_srst = 1;
    edge_step();
    hpi_rst_n = 1;
  endtask

  task automatic illegal_start(input logic [1:0] sel, input logic [15:0] d);
    hpi_addr = sel; hpi_data_in = d; hpi_cs_n = 0; hpi_r_n = 0; hpi_w_n = 0;
    ev_ill = 1;
    edge_step();
    hpi_cs_n = 1; hpi_r_n = 1; hpi_w_n = 1;
    edge_step();
  endtask

  initial begin
    logic [15:0] v;
    int k;
    {ev_wr, ev_rd, ev_ill, ev_post, ev_ack, ev_srst} = '0;
    ev_sel = 0; ev_data = 0; ev_post_data = 0;
    repeat (3) @(posedge clk_clk);
    #1 reset_reset_n = 1'b1;
    edge_step();

    host_read(2'd3, 0, 0, v); chk("reset_status", v, 16'h0000);
    host_read(2'd2, 0, 0, v); chk("reset_address", v, 16'h0000);

    host_write(2'd2, 16'h0000, 0);
    for (int i = 0; i < 256; i++) host_write(2'd0, 16'($urandom), 0);
    host_read(2'd2, 0, 0, v); chk("fill_address", v, 16'h0200);

    host_write(2'd2, 16'h0010, 0);
    host_write(2'd0, 16'hAAAA, 0);
    host_write(2'd0, 16'h5555, 0);
    host_write(2'd0, 16'h1234, 0);
    host_write(2'd2, 16'h0010, 0);
    host_read(2'd0, 0, 0, v); chk("burst_rd0", v, 16'hAAAA);
    host_read(2'd0, 0, 0, v); chk("burst_rd1", v, 16'h5555);
    host_read(2'd0, 0, 0, v); chk("burst_rd2", v, 16'h1234);
    host_read(2'd2, 0, 0, v); chk("burst_addr", v, 16'h0016);

    host_write(2'd2, 16'hFFFE, 0);
    host_write(2'd0, 16'hBEEF, 0);
    host_read(2'd2, 0, 0, v); chk("wrap_addr", v, 16'h0000);
    host_write(2'd2, 16'h01FE, 0);
    host_read(2'd0, 0, 0, v); chk("wrap_alias", v, 16'hBEEF);

    host_write(2'd1, 16'h00C3, 0);
    chk("mbx_in_valid_lit", {15'd0, mbx_in_valid}, 16'h0001);
    chk("mbx_in_data_lit", mbx_in_data, 16'h00C3);
    host_read(2'd3, 0, 0, v); chk("status_valid", v, 16'h0100);
    host_write(2'd1, 16'h00C4, 0);
    host_read(2'd3, 0, 0, v); chk("status_overrun", v, 16'h0300);
    local_ack();
    host_read(2'd3, 0, 0, v); chk("status_acked", v, 16'h0200);

    soft_reset();
    local_post(16'h7E57);
    @(negedge clk_clk); chk("int_after_post", {15'd0, hpi_int}, 16'h0001);
    host_read(2'd3, 0, 0, v); chk("status_busy", v, 16'h0001);
    local_post(16'h1111);
    host_read(2'd1, 0, 0, v); chk("mbx_read", v, 16'h7E57);
    chk("int_cleared", {15'd0, hpi_int}, 16'h0000);
    local_post(16'h5A5A);
    host_read(2'd1, 1, 16'h4242, v); chk("mbx_read_old", v, 16'h5A5A);
    chk("int_held", {15'd0, hpi_int}, 16'h0001);
    host_read(2'd1, 0, 0, v); chk("mbx_read_new", v, 16'h4242);

    host_write(2'd1, 16'h1357, 1);
    chk("ack_vs_write_valid", {15'd0, mbx_in_valid}, 16'h0001);
    chk("ack_vs_write_data", mbx_in_data, 16'h1357);

    host_write(2'd2, 16'h0010, 0);
    illegal_start(2'd0, 16'hDEAD);
    host_read(2'd3, 0, 0, v); chk("status_error", v, 16'h8100);
    host_read(2'd2, 0, 0, v); chk("illegal_addr", v, 16'h0010);
    host_read(2'd0, 0, 0, v); chk("illegal_mem", v, 16'hAAAA);
    soft_reset();
    host_read(2'd3, 0, 0, v); chk("srst_status", v, 16'h0000);
    host_read(2'd2, 0, 0, v); chk("srst_addr", v, 16'h0000);
    host_write(2'd2, 16'h0012, 0);
    host_read(2'd0, 0, 0, v); chk("srst_mem_kept", v, 16'h5555);

    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 99);
      if (k < 30)      host_write(2'($urandom), 16'($urandom), $urandom_range(0, 4) == 0);
      else if (k < 60) host_read(2'($urandom), $urandom_range(0, 4) == 0, 16'($urandom), v);
      else if (k < 72) local_post(16'($urandom));
      else if (k < 82) local_ack();
      else if (k < 90) edge_step();
      else if (k < 94) illegal_start(2'($urandom), 16'($urandom));
      else if (k < 97) soft_reset();
      else             host_write(2'd2, 16'($urandom_range(0, 511)), 0);
    end

    repeat (3) edge_step();
    @(negedge clk_clk);
    done = 1'b1;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
